// File: rtl/riscv_hazard_scoreboard.sv
// Hazard and interlock unit between decode and execute: a countdown scoreboard per register plus
// an occupancy counter for the single non-pipelined multiply/divide unit.
module riscv_hazard_scoreboard #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned LD_LAT     = 2,
  parameter int unsigned MD_LAT     = 4,
  parameter int unsigned CNT_W      = 3,
  parameter int unsigned RA_IDX     = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  input  logic                     flush,
  input  logic [4:0]               opcode,
  input  logic                     i_bit,
  input  logic [ADDR_WIDTH-1:0]    rs1,
  input  logic [ADDR_WIDTH-1:0]    rs2,
  input  logic [ADDR_WIDTH-1:0]    rd,
  output logic                     stall,
  output logic                     issue,
  output logic                     rs1_fwd,
  output logic                     rs2_fwd,
  output logic                     rd_fwd,
  output logic [2**ADDR_WIDTH-1:0] busy_vec,
  output logic                     md_busy,
  output logic [DATA_WIDTH-1:0]    stall_cycles
);

  localparam int unsigned NReg = 2 ** ADDR_WIDTH;

  localparam logic [4:0] OpAdd  = 5'd0;
  localparam logic [4:0] OpSub  = 5'd1;
  localparam logic [4:0] OpMul  = 5'd2;
  localparam logic [4:0] OpDiv  = 5'd3;
  localparam logic [4:0] OpMod  = 5'd4;
  localparam logic [4:0] OpCmp  = 5'd5;
  localparam logic [4:0] OpAnd  = 5'd6;
  localparam logic [4:0] OpOr   = 5'd7;
  localparam logic [4:0] OpNot  = 5'd8;
  localparam logic [4:0] OpMov  = 5'd9;
  localparam logic [4:0] OpLsl  = 5'd10;
  localparam logic [4:0] OpLsr  = 5'd11;
  localparam logic [4:0] OpAsr  = 5'd12;
  localparam logic [4:0] OpLd   = 5'd14;
  localparam logic [4:0] OpSt   = 5'd15;
  localparam logic [4:0] OpCall = 5'd19;
  localparam logic [4:0] OpRet  = 5'd20;

  localparam logic [ADDR_WIDTH-1:0] RaIdx = ADDR_WIDTH'(RA_IDX);
  localparam logic [CNT_W-1:0]      CntOne = CNT_W'(1);

  logic [CNT_W-1:0]      cnt_q [NReg];
  logic [CNT_W-1:0]      cnt_d [NReg];
  logic [CNT_W-1:0]      md_cnt_q, md_cnt_d;
  logic [DATA_WIDTH-1:0] stall_cycles_q, stall_cycles_d;

  logic                  rd_rs1, rd_rs2, rd_rd, wr_en, is_md;
  logic [ADDR_WIDTH-1:0] rs1_eff, rd_eff;
  logic [CNT_W-1:0]      lat;
  logic                  raw, waw, structural, active;

  // Operand usage and latency class
  always_comb begin
    rd_rs1  = 1'b0;
    rd_rs2  = 1'b0;
    rd_rd   = 1'b0;
    wr_en   = 1'b0;
    is_md   = 1'b0;
    rs1_eff = rs1;
    rd_eff  = rd;
    lat     = CntOne;
    unique case (opcode)
      OpAdd, OpSub, OpAnd, OpOr, OpLsl, OpLsr, OpAsr: begin
        rd_rs1 = 1'b1;
        rd_rs2 = !i_bit;
        wr_en  = 1'b1;
      end
      OpMul, OpDiv, OpMod: begin
        rd_rs1 = 1'b1;
        rd_rs2 = !i_bit;
        wr_en  = 1'b1;
        is_md  = 1'b1;
        lat    = CNT_W'(MD_LAT);
      end
      OpCmp: begin
        rd_rs1 = 1'b1;
        rd_rs2 = !i_bit;
      end
      OpNot, OpMov: begin
        rd_rs2 = !i_bit;
        wr_en  = 1'b1;
      end
      OpLd: begin
        rd_rs1 = 1'b1;
        wr_en  = 1'b1;
        lat    = CNT_W'(LD_LAT);
      end
      OpSt: begin
        rd_rs1 = 1'b1;
        rd_rd  = 1'b1;
      end
      OpCall: begin
        wr_en  = 1'b1;
        rd_eff = RaIdx;
      end
      // RET's implicit return-address read travels on the rs1 operand path
      OpRet: begin
        rd_rs1  = 1'b1;
        rs1_eff = RaIdx;
      end
      default: ;
    endcase
  end

  always_comb begin
    raw = (rd_rs1 && (cnt_q[rs1_eff] > CntOne)) ||
          (rd_rs2 && (cnt_q[rs2] > CntOne)) ||
          (rd_rd && (cnt_q[rd] > CntOne));
    waw        = wr_en && (cnt_q[rd_eff] > lat);
    structural = is_md && (md_cnt_q != '0);
    active     = issue_valid && !flush;
    stall      = active && (raw || waw || structural);
    issue      = active && !stall;
    rs1_fwd    = rd_rs1 && (cnt_q[rs1_eff] == CntOne);
    rs2_fwd    = rd_rs2 && (cnt_q[rs2] == CntOne);
    rd_fwd     = rd_rd && (cnt_q[rd] == CntOne);
  end

  always_comb begin
    for (int r = 0; r < NReg; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CntOne : '0;
      if (issue && wr_en && (rd_eff == ADDR_WIDTH'(r))) begin
        cnt_d[r] = lat;
      end
      busy_vec[r] = (cnt_q[r] != '0);
    end
    md_cnt_d = (md_cnt_q != '0) ? md_cnt_q - CntOne : '0;
    if (issue && is_md) begin
      md_cnt_d = CNT_W'(MD_LAT);
    end
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + DATA_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NReg; r++) begin
        cnt_q[r] <= '0;
      end
      md_cnt_q       <= '0;
      stall_cycles_q <= '0;
    end else begin
      for (int r = 0; r < NReg; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      md_cnt_q       <= md_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign md_busy      = (md_cnt_q != '0);
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_riscv_hazard_scoreboard.sv
// Directed, table-driven bench for riscv_hazard_scoreboard (LD_LAT=2, MD_LAT=4, 16 registers),
// with a narrow-counter second instance to exercise stall_cycles saturation.
module tb_riscv_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  opcode = '0;
  logic        i_bit = 1'b0;
  logic [3:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic        stall, issue, rs1_fwd, rs2_fwd, rd_fwd, md_busy;
  logic [15:0] busy_vec;
  logic [31:0] stall_cycles;
  logic        stall2, issue2, rs1_fwd2, rs2_fwd2, rd_fwd2, md_busy2;
  logic [15:0] busy_vec2;
  logic [1:0]  stall_cycles2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  riscv_hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .flush(flush), .opcode(opcode),
    .i_bit(i_bit), .rs1(rs1), .rs2(rs2), .rd(rd), .stall(stall), .issue(issue),
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .rd_fwd(rd_fwd), .busy_vec(busy_vec),
    .md_busy(md_busy), .stall_cycles(stall_cycles)
  );

  riscv_hazard_scoreboard #(.DATA_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .flush(flush), .opcode(opcode),
    .i_bit(i_bit), .rs1(rs1), .rs2(rs2), .rd(rd), .stall(stall2), .issue(issue2),
    .rs1_fwd(rs1_fwd2), .rs2_fwd(rs2_fwd2), .rd_fwd(rd_fwd2), .busy_vec(busy_vec2),
    .md_busy(md_busy2), .stall_cycles(stall_cycles2)
  );

  typedef struct {
    bit         v;
    bit         fl;
    logic [4:0] op;
    bit         ib;
    logic [3:0] r1, r2, rdx;
    bit         st;
    bit         is;
    logic [2:0] fw;
    logic [15:0] bv;
    bit         md;
    int         sc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit v, bit fl, int op, bit ib, int r1, int r2, int rdx,
                              bit st, bit is, int fw, int bv, bit md, int sc);
    vec_t t;
    t.v = v; t.fl = fl; t.op = 5'(op); t.ib = ib;
    t.r1 = 4'(r1); t.r2 = 4'(r2); t.rdx = 4'(rdx);
    t.st = st; t.is = is; t.fw = 3'(fw); t.bv = 16'(bv); t.md = md; t.sc = sc;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input bit v, input bit fl, input logic [4:0] op, input bit ib,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    issue_valid = v; flush = fl; opcode = op; i_bit = ib; rs1 = a; rs2 = b; rd = c;
  endtask

  initial begin
    // v fl op ib rs1 rs2 rd | stall issue fwd{rs1,rs2,rd} busy_vec md_busy stall_cycles
    vecs.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0,'h0000,0, 0)); // c0 idle after reset
    vecs.push_back(mk(1,0, 0,0, 2,3,1, 0,1,0,'h0000,0, 0)); // ADD r1
    vecs.push_back(mk(1,0, 0,0, 1,3,2, 0,1,4,'h0002,0, 0)); // ADD r2,r1 -> fwd
    vecs.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0,'h0004,0, 0));
    vecs.push_back(mk(1,0,14,0, 0,0,4, 0,1,0,'h0000,0, 0)); // LD r4
    vecs.push_back(mk(1,0, 1,0, 4,6,5, 1,0,0,'h0010,0, 0)); // SUB r5,r4 stalls
    vecs.push_back(mk(1,0, 1,0, 4,6,5, 0,1,4,'h0010,0, 1));
    vecs.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0,'h0020,0, 1));
    vecs.push_back(mk(1,0, 2,0, 1,2,7, 0,1,0,'h0000,0, 1)); // MUL r7
    vecs.push_back(mk(1,0, 0,0, 1,2,9, 0,1,0,'h0080,1, 1)); // independent ADD r9
    vecs.push_back(mk(1,0, 9,0, 0,7,8, 1,0,0,'h0280,1, 1)); // MOV r8,r7
    vecs.push_back(mk(1,0, 9,0, 0,7,8, 1,0,0,'h0080,1, 2));
    vecs.push_back(mk(1,0, 9,0, 0,7,8, 0,1,2,'h0080,1, 3));
    vecs.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0,'h0100,0, 3));
    vecs.push_back(mk(1,0, 2,0, 2,3,1, 0,1,0,'h0000,0, 3)); // MUL r1
    vecs.push_back(mk(1,0, 3,0, 4,5,2, 1,0,0,'h0002,1, 3)); // DIV r2: structural
    vecs.push_back(mk(1,0, 3,0, 4,5,2, 1,0,0,'h0002,1, 4));
    vecs.push_back(mk(1,0, 3,0, 4,5,2, 1,0,0,'h0002,1, 5));
    vecs.push_back(mk(1,0, 3,0, 4,5,2, 1,0,0,'h0002,1, 6));
    vecs.push_back(mk(1,0, 3,0, 4,5,2, 0,1,0,'h0000,0, 7));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0,'h0004,1, 7));
    vecs.push_back(mk(1,0, 3,0, 4,5,3, 0,1,0,'h0000,0, 7)); // DIV r3
    vecs.push_back(mk(1,0, 0,0, 1,2,3, 1,0,0,'h0008,1, 7)); // ADD r3: WAW
    vecs.push_back(mk(1,0, 0,0, 1,2,3, 1,0,0,'h0008,1, 8));
    vecs.push_back(mk(1,0, 0,0, 1,2,3, 1,0,0,'h0008,1, 9));
    vecs.push_back(mk(1,0, 0,0, 1,2,3, 0,1,0,'h0008,1,10));
    vecs.push_back(mk(1,0,19,0, 0,0,0, 0,1,0,'h0008,0,10)); // CALL
    vecs.push_back(mk(1,0,20,0, 0,0,0, 0,1,4,'h8000,0,10)); // RET reads r15
    vecs.push_back(mk(1,0, 0,0, 0,0,6, 0,1,0,'h0000,0,10)); // ADD r6
    vecs.push_back(mk(1,0,15,0, 0,0,6, 0,1,1,'h0040,0,10)); // ST data r6
    vecs.push_back(mk(1,1,14,0, 0,0,2, 0,0,0,'h0000,0,10)); // flushed LD r2
    vecs.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0,'h0000,0,10));
    vecs.push_back(mk(1,0,14,0, 0,0,4, 0,1,0,'h0000,0,10)); // LD r4
    vecs.push_back(mk(1,0, 0,1, 1,4,5, 0,1,0,'h0010,0,10)); // ADD imm: rs2 unread
    vecs.push_back(mk(1,0, 5,0, 4,5,0, 0,1,6,'h0030,0,10)); // CMP r4,r5
    vecs.push_back(mk(1,0,14,0, 0,0,4, 0,1,0,'h0000,0,10)); // LD r4
    vecs.push_back(mk(1,1, 1,0, 4,6,5, 0,0,0,'h0010,0,10)); // flush masks stall
    vecs.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0,'h0010,0,10));
    vecs.push_back(mk(1,0,25,0, 4,4,4, 0,1,0,'h0000,0,10)); // undefined opcode

    // Reset state while rst_n is held low
    #2;
    chk("rst_busy_vec", -1, 32'(busy_vec), 0);
    chk("rst_md_busy", -1, 32'(md_busy), 0);
    chk("rst_stall_cycles", -1, stall_cycles, 0);
    chk("rst_stall", -1, 32'(stall), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].fl, vecs[i].op, vecs[i].ib, vecs[i].r1, vecs[i].r2,
            vecs[i].rdx);
      @(negedge clk);
      chk("stall", i, 32'(stall), 32'(vecs[i].st));
      chk("issue", i, 32'(issue), 32'(vecs[i].is));
      chk("fwd", i, 32'({rs1_fwd, rs2_fwd, rd_fwd}), 32'(vecs[i].fw));
      chk("busy_vec", i, 32'(busy_vec), 32'(vecs[i].bv));
      chk("md_busy", i, 32'(md_busy), 32'(vecs[i].md));
      chk("stall_cycles", i, stall_cycles, 32'(vecs[i].sc));
      @(posedge clk);
      #1;
    end
    chk("stall_cycles_sat", 0, 32'(stall_cycles2), 3);

    // MUL in flight, then asynchronous reset mid-cycle
    drive(1, 0, 5'd2, 0, 4'd1, 4'd2, 4'd7);
    @(posedge clk);
    #1;
    drive(0, 0, 5'd0, 0, 4'd0, 4'd0, 4'd0);
    chk("inflight_busy_vec", 0, 32'(busy_vec), 'h0080);
    chk("inflight_md_busy", 0, 32'(md_busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy_vec", 0, 32'(busy_vec), 0);
    chk("midrst_md_busy", 0, 32'(md_busy), 0);
    chk("midrst_stall_cycles", 0, stall_cycles, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 0, 5'd2, 0, 4'd7, 4'd7, 4'd8); // MUL r8,r7,r7 right after reset
    @(negedge clk);
    chk("postrst_stall", 0, 32'(stall), 0);
    chk("postrst_issue", 0, 32'(issue), 1);
    chk("postrst_fwd", 0, 32'({rs1_fwd, rs2_fwd, rd_fwd}), 0);
    @(posedge clk);
    #1;
    drive(0, 0, 5'd0, 0, 4'd0, 4'd0, 4'd0);
    chk("postrst_busy_vec", 0, 32'(busy_vec), 'h0100);
    chk("postrst_md_busy", 0, 32'(md_busy), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
